// File: rtl/refill_pkg.sv
// Shared types and constants for the data-cache miss/refill controller.
package refill_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        DONE
    } refill_state_t;

    localparam logic [3:0] BE_WORD  = 4'b1111;
    localparam logic [3:0] BE_BYTE0 = 4'b0001;

    localparam int DEFAULT_TIMEOUT = 64;

    // Byte-lane enable for a single-byte store at the given word offset.
    function automatic logic [3:0] byte_lane(input logic [1:0] offset);
        return BE_BYTE0 << offset;
    endfunction

endpackage

// File: rtl/refill_timer.sv
// Clearable up-counter that flags when a memory wait has lasted LIMIT cycles.
module refill_timer #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic terminal
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] count;

    // Count waiting cycles; hold at the terminal value until cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && !terminal) begin
            count <= count + CW'(1);
        end
    end

    assign terminal = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss/refill controller between the MEM-stage data cache and main memory.
// Refills loads through a one-cycle fill strobe and writes stores through.
module cache_refill_ctrl
    import refill_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic                  ld_req,
    input  logic                  st_req,
    input  logic                  st_byte,
    input  logic                  hit,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic [3:0]            mem_be,
    output logic                  mem_re,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rd,
    input  logic                  mem_ack,
    output logic                  stall,
    output logic                  fill_en,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic [DATA_WIDTH-1:0] fill_data,
    output logic [CNT_WIDTH-1:0]  miss_count,
    output logic                  err
);

    refill_state_t state;
    logic          waiting;
    logic          timed_out;

    assign waiting = (state == RD_WAIT) || (state == WR_WAIT);

    // The wait timer is held clear outside the wait states, so it starts at zero on entry.
    refill_timer #(
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (!waiting),
        .en       (waiting),
        .terminal (timed_out)
    );

    // The fill address is simply the address captured for the outstanding request.
    assign fill_addr = mem_addr;

    // Stall decision: immediate in IDLE so the requesting instruction freezes in its own cycle.
    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = (ld_req && !hit) || st_req;
            RD_WAIT: stall = 1'b1;
            WR_WAIT: stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    // Main FSM with registered memory handshake, capture registers, miss counter and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mem_addr   <= '0;
            mem_wd     <= '0;
            mem_be     <= '0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            fill_en    <= 1'b0;
            fill_data  <= '0;
            miss_count <= '0;
            err        <= 1'b0;
        end else begin
            fill_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (st_req) begin
                        mem_addr <= addr;
                        mem_be   <= st_byte ? byte_lane(addr[1:0]) : BE_WORD;
                        mem_wd   <= st_byte ? {(DATA_WIDTH/8){wd[7:0]}} : wd;
                        mem_we   <= 1'b1;
                        state    <= WR_WAIT;
                    end else if (ld_req && !hit) begin
                        mem_addr <= addr;
                        mem_re   <= 1'b1;
                        if (miss_count != '1) begin
                            miss_count <= miss_count + CNT_WIDTH'(1);
                        end
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (mem_ack) begin
                        fill_data <= mem_rd;
                        mem_re    <= 1'b0;
                        fill_en   <= 1'b1;
                        state     <= DONE;
                    end else if (timed_out) begin
                        err       <= 1'b1;
                        fill_data <= '0;
                        mem_re    <= 1'b0;
                        fill_en   <= 1'b1;
                        state     <= DONE;
                    end
                end
                WR_WAIT: begin
                    if (mem_ack || timed_out) begin
                        if (!mem_ack) begin
                            err <= 1'b1;
                        end
                        mem_we <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: the driver queues expected memory
// requests and fills, a monitor pops and compares them as the DUT emits them.
module tb_cache_refill_ctrl;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   addr, wd, mem_rd;
    logic          ld_req, st_req, st_byte, hit, mem_ack;
    logic [31:0]   mem_addr, mem_wd, fill_addr, fill_data;
    logic [3:0]    mem_be;
    logic          mem_re, mem_we, stall, fill_en, err;
    logic [CW-1:0] miss_count;

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
    } req_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } fill_t;

    req_t  req_q[$];
    fill_t fill_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int sc;

    cache_refill_ctrl #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .TIMEOUT    (8),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .wd         (wd),
        .ld_req     (ld_req),
        .st_req     (st_req),
        .st_byte    (st_byte),
        .hit        (hit),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_be     (mem_be),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd),
        .mem_ack    (mem_ack),
        .stall      (stall),
        .fill_en    (fill_en),
        .fill_addr  (fill_addr),
        .fill_data  (fill_data),
        .miss_count (miss_count),
        .err        (err)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one MEM-stage request, queue its expected results, answer with mem_ack
    // on wait cycle ack_at (0 = never) and return how many cycles stall was high.
    task automatic applyStimulus(input logic ld, input logic st, input logic sb, input logic h,
                                 input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd,
                                 input int ack_at, input logic [3:0] exp_be,
                                 input logic [31:0] exp_wd, input logic [31:0] exp_fill,
                                 output int stall_cycles);
        req_t  r;
        fill_t f;
        if (st) begin
            r.is_wr = 1'b1; r.addr = a; r.wd = exp_wd; r.be = exp_be;
            req_q.push_back(r);
        end else if (ld && !h) begin
            r.is_wr = 1'b0; r.addr = a; r.wd = '0; r.be = '0;
            req_q.push_back(r);
            f.addr = a; f.data = exp_fill;
            fill_q.push_back(f);
        end
        stall_cycles = 0;
        @(negedge clk);
        ld_req = ld; st_req = st; st_byte = sb; hit = h; addr = a; wd = d;
        #1;
        if (stall) stall_cycles++;
        for (int n = 1; n < 50; n++) begin
            @(negedge clk);
            ld_req  = 1'b0;
            st_req  = 1'b0;
            mem_ack = (n == ack_at);
            mem_rd  = (n == ack_at) ? rd : 32'h0;
            #1;
            if (!stall) break;
            stall_cycles++;
            if (n == 49) checkOutput("stall_bound", 32'(stall), 32'h0);
        end
    endtask

    // Monitor: compare each new memory request and each fill strobe against the queues.
    logic prev_re = 1'b0;
    logic prev_we = 1'b0;
    initial begin
        req_t  r;
        fill_t f;
        forever begin
            @(negedge clk);
            if ((mem_re && !prev_re) || (mem_we && !prev_we)) begin
                checkOutput("re_we_exclusive", 32'(mem_re & mem_we), 32'h0);
                if (req_q.size() == 0) begin
                    checkOutput("unexpected_request", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    r = req_q.pop_front();
                    checkOutput("req_kind_we", 32'(mem_we), 32'(r.is_wr));
                    checkOutput("req_kind_re", 32'(mem_re), 32'(!r.is_wr));
                    checkOutput("req_addr", mem_addr, r.addr);
                    if (r.is_wr) begin
                        checkOutput("req_wd", mem_wd, r.wd);
                        checkOutput("req_be", 32'(mem_be), 32'(r.be));
                    end
                end
            end
            if (fill_en) begin
                if (fill_q.size() == 0) begin
                    checkOutput("unexpected_fill", fill_addr, 32'hFFFF_FFFF);
                end else begin
                    f = fill_q.pop_front();
                    checkOutput("fill_addr", fill_addr, f.addr);
                    checkOutput("fill_data", fill_data, f.data);
                end
            end
            prev_re = mem_re;
            prev_we = mem_we;
        end
    end

    // Directed test sequence.
    initial begin
        req_t r;
        rst = 1'b1; addr = '0; wd = '0; mem_rd = '0;
        ld_req = 1'b0; st_req = 1'b0; st_byte = 1'b0; hit = 1'b0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_mem_re", 32'(mem_re), 32'h0);
        checkOutput("reset_mem_we", 32'(mem_we), 32'h0);
        checkOutput("reset_stall", 32'(stall), 32'h0);
        checkOutput("reset_fill_en", 32'(fill_en), 32'h0);
        checkOutput("reset_miss_count", 32'(miss_count), 32'h0);
        checkOutput("reset_err", 32'(err), 32'h0);
        checkOutput("reset_mem_addr", mem_addr, 32'h0);
        checkOutput("reset_fill_data", fill_data, 32'h0);

        // Load miss, ack on third cycle of mem_re.
        applyStimulus(1, 0, 0, 0, 32'h0001_0004, 32'h0, 32'hDEAD_BEEF, 3, 4'h0, 32'h0, 32'hDEAD_BEEF, sc);
        checkOutput("ld_miss_stall", 32'(sc), 32'd4);
        checkOutput("ld_miss_count", 32'(miss_count), 32'd1);

        // Load hit.
        applyStimulus(1, 0, 0, 1, 32'h0001_0008, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, sc);
        checkOutput("ld_hit_stall", 32'(sc), 32'd0);
        checkOutput("ld_hit_count", 32'(miss_count), 32'd1);

        // SB at byte offset 2, immediate ack.
        applyStimulus(0, 1, 1, 0, 32'h0001_0006, 32'h0000_00AB, 32'h0, 1, 4'b0100, 32'hABAB_ABAB, 32'h0, sc);
        checkOutput("sb_stall", 32'(sc), 32'd2);

        // SW, ack on second wait cycle.
        applyStimulus(0, 1, 0, 0, 32'h0002_0000, 32'h1234_5678, 32'h0, 2, 4'b1111, 32'h1234_5678, 32'h0, sc);
        checkOutput("sw_stall", 32'(sc), 32'd3);

        // Store and load miss together: store wins, no miss counted.
        applyStimulus(1, 1, 1, 0, 32'h0003_0001, 32'h0000_005A, 32'h0, 1, 4'b0010, 32'h5A5A_5A5A, 32'h0, sc);
        checkOutput("st_prio_stall", 32'(sc), 32'd2);
        checkOutput("st_prio_count", 32'(miss_count), 32'd1);

        // Reset raised in the middle of RD_WAIT.
        r.is_wr = 1'b0; r.addr = 32'h0006_0000; r.wd = '0; r.be = '0;
        req_q.push_back(r);
        @(negedge clk);
        ld_req = 1'b1; hit = 1'b0; addr = 32'h0006_0000;
        @(negedge clk);
        ld_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_mid_mem_re", 32'(mem_re), 32'h0);
        checkOutput("rst_mid_stall", 32'(stall), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_after_count", 32'(miss_count), 32'h0);
        checkOutput("rst_after_mem_re", 32'(mem_re), 32'h0);
        checkOutput("rst_after_err", 32'(err), 32'h0);

        // Load miss after reset, immediate ack.
        applyStimulus(1, 0, 0, 0, 32'h0004_0008, 32'h0, 32'h0BAD_F00D, 1, 4'h0, 32'h0, 32'h0BAD_F00D, sc);
        checkOutput("ld2_stall", 32'(sc), 32'd2);
        checkOutput("ld2_count", 32'(miss_count), 32'd1);

        // Timeout: no ack, 8 RD_WAIT cycles then fill with zero data.
        applyStimulus(1, 0, 0, 0, 32'h0005_0000, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, sc);
        checkOutput("tmo_stall", 32'(sc), 32'd9);
        checkOutput("tmo_err", 32'(err), 32'h1);
        checkOutput("tmo_count", 32'(miss_count), 32'd2);

        // Error stays set across a later successful store.
        applyStimulus(0, 1, 0, 0, 32'h0007_0000, 32'hCAFE_0001, 32'h0, 1, 4'b1111, 32'hCAFE_0001, 32'h0, sc);
        checkOutput("err_sticky", 32'(err), 32'h1);

        // Three more misses: counter saturates at 3.
        applyStimulus(1, 0, 0, 0, 32'h0008_0000, 32'h0, 32'h1111_1111, 1, 4'h0, 32'h0, 32'h1111_1111, sc);
        checkOutput("sat_count_3", 32'(miss_count), 32'd3);
        applyStimulus(1, 0, 0, 0, 32'h0008_0004, 32'h0, 32'h2222_2222, 1, 4'h0, 32'h0, 32'h2222_2222, sc);
        checkOutput("sat_count_4", 32'(miss_count), 32'd3);
        applyStimulus(1, 0, 0, 0, 32'h0008_0008, 32'h0, 32'h3333_3333, 2, 4'h0, 32'h0, 32'h3333_3333, sc);
        checkOutput("sat_count_5", 32'(miss_count), 32'd3);

        // Stray ack while idle must be ignored.
        @(negedge clk);
        mem_ack = 1'b1; mem_rd = 32'hFFFF_0000;
        @(negedge clk);
        mem_ack = 1'b0;
        checkOutput("idle_ack_mem_re", 32'(mem_re), 32'h0);
        checkOutput("idle_ack_fill_en", 32'(fill_en), 32'h0);
        repeat (3) @(negedge clk);

        checkOutput("req_queue_drained", 32'(req_q.size()), 32'd0);
        checkOutput("fill_queue_drained", 32'(fill_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish, expected finish");
        $fatal(1, "[TB] time limit reached");
    end

endmodule
